// File: rtl/midi_event_queue.sv
// midi_event_queue
// Queues completed 3-byte MIDI messages from midi_monitor into a DEPTH-entry
// FIFO so the CPU can drain them over MMIO without losing back-to-back notes.
//   ADDR_DATA   : read returns the head entry and pops it (once per read strobe)
//   ADDR_STATUS : read returns {21'b0, overflow, full, empty, count[7:0]} and
//                 clears the sticky overflow flag
// Build option: define MIDI_TIMESTAMP_EN to stamp each entry's top byte with a
// coarse 8-bit timestamp (ts_cnt advances every 2^16 clocks). Without it the top
// byte is 8'h00 and the timestamp counter is not built.
//
// Read strobe semantics: a read is "mem_read_enable high with mem_addr on one of
// this block's addresses". Side effects (pop, overflow clear) fire only on the
// first cycle of a contiguous strobe; holding the strobe longer is harmless.
// read_data is combinational and valid in every cycle the address matches.

module midi_event_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] ADDR_DATA   = 32'h2002,
  parameter logic [31:0] ADDR_STATUS = 32'h2003
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     busy_reading,
  input  logic [23:0]              midi_bytes,
  input  logic [31:0]              mem_addr,
  input  logic                     mem_read_enable,
  output logic [31:0]              read_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage (no reset) and control state
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_busy_q;
  logic          r_rd_q;
  logic          r_st_q;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_data_addr;
  logic          w_stat_addr;
  logic          w_data_hit;
  logic          w_stat_hit;
  logic          w_pop;
  logic          w_write;
  logic          w_drop;
  logic          w_stat_clr;
  logic [7:0]    w_ts;
  logic [7:0]    w_count8;
  logic [31:0]   w_read_val;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A message is complete on the falling edge of busy_reading.
  assign w_push = r_busy_q & ~busy_reading;

  assign w_data_addr = (mem_addr == ADDR_DATA);
  assign w_stat_addr = (mem_addr == ADDR_STATUS);
  assign w_data_hit  = mem_read_enable & w_data_addr;
  assign w_stat_hit  = mem_read_enable & w_stat_addr;

  // Pop only on the first cycle of a data read, and never from an empty FIFO.
  assign w_pop = w_data_hit & ~r_rd_q & ~w_empty;

  // A push lands when there is room, or when a pop frees the slot this cycle.
  assign w_write = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  assign w_stat_clr = w_stat_hit & ~r_st_q;

`ifdef MIDI_TIMESTAMP_EN
  logic [15:0] r_prescale;
  logic [7:0]  r_ts_cnt;

  // Free-running coarse timestamp: ts_cnt steps once per 2^16 clocks, wraps at 255.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_ts_cnt   <= '0;
    end else begin
      r_prescale <= r_prescale + 16'd1;
      if (r_prescale == 16'hFFFF) begin
        r_ts_cnt <= r_ts_cnt + 8'd1;
      end
    end
  end

  assign w_ts = r_ts_cnt;
`else
  assign w_ts = 8'h00;
`endif

  // Edge-detect history for busy_reading and the two read strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_q <= 1'b0;
      r_rd_q   <= 1'b0;
      r_st_q   <= 1'b0;
    end else begin
      r_busy_q <= busy_reading;
      r_rd_q   <= w_data_hit;
      r_st_q   <= w_stat_hit;
    end
  end

  // Entry storage: written on an accepted push, never reset.
  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= {w_ts, midi_bytes};
    end
  end

  // Pointers and occupancy; count only moves when exactly one side acts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: set on a dropped message, cleared by a status read; set wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_stat_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_count8 = 8'(r_count);

  // MMIO read mux: head entry (0 when empty) or the status word.
  always_comb begin
    w_read_val = 32'h0000_0000;
    if (w_data_addr) begin
      if (!w_empty) begin
        w_read_val = r_mem[r_rd_ptr];
      end
    end else if (w_stat_addr) begin
      w_read_val = {21'b0, r_overflow, w_full, w_empty, w_count8};
    end
  end

  // Float the bus for foreign addresses so other MMIO sources can share it.
  assign read_data  = (w_data_addr | w_stat_addr) ? w_read_val : 32'bz;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
